// File: rtl/gelu_backward.sv
// GELU backward pass: dx = dy * GELU'(x) with a piecewise-constant derivative.
// Two-stage valid/ready pipeline:
//   S1 holds the selected derivative, the upstream gradient and the last flag.
//   S2 holds the scaled product (dx_out) and out_last.
// The output counter counts transfers within a tensor and clears on the last beat.
// Optional build macro GELU_BWD_SAT_EN saturates the result to the 8-bit range.
// Without the macro, the low 8 bits are kept and the result wraps.
module gelu_backward (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  x_in,
  input  logic [7:0]  g_in,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  dx_out,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_cnt
);

  // Stage 1 state. Only the valid bit is reset.
  logic              s1_valid_q;
  logic              s1_valid_d;
  logic signed [7:0] s1_d_q;
  logic signed [7:0] s1_g_q;
  logic              s1_last_q;

  // Handshake terms
  logic s2_adv;
  logic in_xfer;
  logic out_xfer;

  // Datapath terms
  logic signed [7:0]  x_s;
  logic signed [7:0]  d_sel;
  logic signed [15:0] prod;
  logic signed [9:0]  r;
  logic        [7:0]  dx_next;

  assign x_s = $signed(x_in);

  // S2 can take a new beat when it is empty or its beat leaves this cycle.
  assign s2_adv   = !out_valid || out_ready;
  // in_ready is forced low while reset is asserted.
  assign in_ready = reset && (!s1_valid_q || s2_adv);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Piecewise derivative of GELU in Q1.6, selected from Q3.5 x.
  always_comb begin
    d_sel = 8'sd0;
    if (x_s <= -8'sd80) begin
      d_sel = 8'sd0;
    end else if (x_s < -8'sd16) begin
      d_sel = -8'sd4;
    end else if (x_s < 8'sd0) begin
      d_sel = 8'sd16;
    end else if (x_s < 8'sd64) begin
      d_sel = 8'sd72;
    end else begin
      d_sel = 8'sd64;
    end
  end

  // Full 16-bit signed product.
  // Bits [15:6] equal an arithmetic shift right by 6, i.e. floor(p / 64).
  assign prod = $signed({{8{s1_g_q[7]}}, s1_g_q}) * $signed({{8{s1_d_q[7]}}, s1_d_q});
  assign r    = prod[15:6];

  // Reduce the 10-bit result to the 8-bit output format.
  always_comb begin
    dx_next = r[7:0];
`ifdef GELU_BWD_SAT_EN
    if (r > 10'sd127) begin
      dx_next = 8'h7f;
    end else if (r < -10'sd128) begin
      dx_next = 8'h80;
    end
`endif
  end

  // S1 occupancy: a free or draining S1 takes whatever is offered.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
  end

  // S1 valid register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  // S1 data registers load on accepted input beats only.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_d_q    <= d_sel;
      s1_g_q    <= $signed(g_in);
      s1_last_q <= in_last;
    end
  end

  // S2 output register.
  // The register holds its value while a stalled beat waits for out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      dx_out    <= 8'h00;
      out_last  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        dx_out   <= dx_next;
        out_last <= s1_last_q;
      end
    end
  end

  // Per-tensor transfer counter.
  // A last-beat transfer clears the counter. Otherwise the count increments and wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt <= 16'h0000;
    end else if (out_xfer) begin
      if (out_last) begin
        out_cnt <= 16'h0000;
      end else begin
        out_cnt <= out_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_gelu_backward.sv
// Directed, table-driven bench for gelu_backward.
// The bench covers:
//   - single-beat vectors with latency checks
//   - back-to-back input with an output stall
//   - tensor-last handling of the counter
//   - counter wrap
//   - reset with beats in flight
module tb_gelu_backward;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x_in;
  logic [7:0]  g_in;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dx_out;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cnt;

  gelu_backward dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .g_in      (g_in),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dx_out    (dx_out),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] x;
    logic signed [7:0] g;
    logic signed [7:0] dx;
  } vec_t;

  localparam int NV = 15;

`ifdef GELU_BWD_SAT_EN
  localparam int E32_POS = 127;
  localparam int E32_NEG = -128;
`else
  localparam int E32_POS = -114;
  localparam int E32_NEG = 112;
`endif

  vec_t vt [NV];

  // Beat lists for the multi-beat sequences
  logic signed [7:0] bx   [8];
  logic signed [7:0] bg   [8];
  logic signed [7:0] bexp [8];
  logic              bl   [8];

  int n_checks  = 0;
  int n_pass    = 0;
  int cnt_model = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x, input int g, input int dx);
    vec_t v;
    v.x  = 8'(x);
    v.g  = 8'(g);
    v.dx = 8'(dx);
    return v;
  endfunction

  // Offer beats 0..n-1 in order.
  // Acceptance is judged at the negedge before the capturing posedge.
  task automatic drive_beats(input int n);
    for (int i = 0; i < n; i++) begin
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      x_in     = bx[i];
      g_in     = bg[i];
      in_last  = bl[i];
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1'b1;
          break;
        end
      end
      if (!acc) begin
        chk($sformatf("drive_accept%0d", i), 0, 1);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Observe n output transfers.
  // For each transfer, check the value and last flag, then the counter after the edge.
  task automatic collect(input int n);
    for (int k = 0; k < n; k++) begin
      bit got;
      got = 1'b0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        chk($sformatf("collect_timeout%0d", k), 0, 1);
        break;
      end
      chk($sformatf("beat%0d_dx", k), $signed(dx_out), bexp[k]);
      chk($sformatf("beat%0d_last", k), int'(out_last), int'(bl[k]));
      cnt_model = bl[k] ? 0 : ((cnt_model + 1) % 65536);
      @(posedge clk);
      #1;
      chk($sformatf("beat%0d_cnt", k), int'(out_cnt), cnt_model);
    end
  endtask

  // Hold off the first output for three cycles.
  // While the output is stalled, check the held value and that in_ready drops.
  task automatic stall_first();
    bit               seen;
    logic signed [7:0] held;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_first_output", int'(seen), 1);
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready_low", int'(in_ready), 0);
    held = $signed(dx_out);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_hold%0d", c), int'(out_valid && ($signed(dx_out) == held)), 1);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    vt[0]  = mk(-100,   64,    0);
    vt[1]  = mk( -40,   64,   -4);
    vt[2]  = mk( -16,  127,   31);
    vt[3]  = mk( 100, -128, -128);
    vt[4]  = mk(  32,  127, E32_POS);
    vt[5]  = mk(  32, -128, E32_NEG);
    vt[6]  = mk( -80,   64,    0);
    vt[7]  = mk( -79,   64,   -4);
    vt[8]  = mk( -17,  -64,    4);
    vt[9]  = mk(  -1,   -1,   -1);
    vt[10] = mk(   0,    1,    1);
    vt[11] = mk(  63,   -1,   -2);
    vt[12] = mk(  64,   -1,   -1);
    vt[13] = mk( 127,  127,  127);
    vt[14] = mk(-128, -128,    0);

    in_valid  = 1'b0;
    in_last   = 1'b0;
    x_in      = 8'h00;
    g_in      = 8'h00;
    out_ready = 1'b1;
    reset     = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_cnt", int'(out_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_dx_out", int'(dx_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("in_ready_after_release", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Single beats: out_valid stays low one edge after capture and rises after the next.
    for (int i = 0; i < NV; i++) begin
      x_in     = vt[i].x;
      g_in     = vt[i].g;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), int'(out_valid), 0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("vec%0d_dx", i), $signed(dx_out), vt[i].dx);
    end
    @(posedge clk);
    #1;
    cnt_model = NV;
    chk("table_cnt", int'(out_cnt), cnt_model);

    // Four back-to-back beats with the first output stalled three cycles
    bx[0] = -40;  bg[0] = 64;   bexp[0] = -4;   bl[0] = 1'b0;
    bx[1] = -16;  bg[1] = 127;  bexp[1] = 31;   bl[1] = 1'b0;
    bx[2] = 100;  bg[2] = -128; bexp[2] = -128; bl[2] = 1'b0;
    bx[3] = 0;    bg[3] = 1;    bexp[3] = 1;    bl[3] = 1'b0;
    fork
      drive_beats(4);
      collect(4);
      stall_first();
    join

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive_beats(2);
    chk("pre_reset_valid", int'(out_valid), 1);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_cnt", int'(out_cnt), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        if (out_valid) begin
          seen = 1'b1;
        end
      end
      chk("no_ghost_after_reset", int'(seen), 0);
    end
    cnt_model = 0;

    // Five-beat tensor: count 1..4, then a clear on the last beat
    bx[0] = 0;   bg[0] = 64;  bexp[0] = 72;  bl[0] = 1'b0;
    bx[1] = -1;  bg[1] = 64;  bexp[1] = 16;  bl[1] = 1'b0;
    bx[2] = 70;  bg[2] = -64; bexp[2] = -64; bl[2] = 1'b0;
    bx[3] = -50; bg[3] = 64;  bexp[3] = -4;  bl[3] = 1'b0;
    bx[4] = -90; bg[4] = 100; bexp[4] = 0;   bl[4] = 1'b1;
    fork
      drive_beats(5);
      collect(5);
    join

    // Counter wrap: 65535 streaming transfers without last, then one more
    x_in     = 8'h00;
    g_in     = 8'h00;
    in_last  = 1'b0;
    in_valid = 1'b1;
    begin
      int n;
      n = 0;
      for (int it = 0; it < 70000; it++) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          n++;
        end
        if (n == 65535) begin
          break;
        end
      end
      chk("wrap_transfers", n, 65535);
    end
    @(posedge clk);
    #1;
    chk("wrap_cnt_max", int'(out_cnt), 65535);
    @(negedge clk);
    chk("wrap_next_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("wrap_cnt_zero", int'(out_cnt), 0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
